// File: rtl/dnn_operand_sequencer.sv
// dnn_operand_sequencer
// Initiator side of the DNN operand/result interface. It collects a serial
// stream of 32 operand words into the parallel x*/w* bus, pulses in_ready
// for one cycle, gathers the two DNN results on their own strobes, and
// offers the result set upstream through a valid/ready handshake.
// Words 28..31 of each stream are accepted and discarded; only the first 28
// words have operand registers.

module dnn_operand_sequencer #(
  parameter int WORD_W  = 5,
  parameter int OUT_W   = 17,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,

  output logic [WORD_W-1:0] x0,
  output logic [WORD_W-1:0] x1,
  output logic [WORD_W-1:0] x2,
  output logic [WORD_W-1:0] x3,
  output logic [WORD_W-1:0] w04,
  output logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w24,
  output logic [WORD_W-1:0] w34,
  output logic [WORD_W-1:0] w05,
  output logic [WORD_W-1:0] w15,
  output logic [WORD_W-1:0] w25,
  output logic [WORD_W-1:0] w35,
  output logic [WORD_W-1:0] w06,
  output logic [WORD_W-1:0] w16,
  output logic [WORD_W-1:0] w26,
  output logic [WORD_W-1:0] w36,
  output logic [WORD_W-1:0] w07,
  output logic [WORD_W-1:0] w17,
  output logic [WORD_W-1:0] w27,
  output logic [WORD_W-1:0] w37,
  output logic [WORD_W-1:0] w48,
  output logic [WORD_W-1:0] w58,
  output logic [WORD_W-1:0] w68,
  output logic [WORD_W-1:0] w78,
  output logic [WORD_W-1:0] w49,
  output logic [WORD_W-1:0] w59,
  output logic [WORD_W-1:0] w69,
  output logic [WORD_W-1:0] w79,

  output logic              in_ready,
  input  logic [OUT_W-1:0]  out0,
  input  logic [OUT_W-1:0]  out1,
  input  logic              out0_ready,
  input  logic              out1_ready,

  output logic [OUT_W-1:0]  res0,
  output logic [OUT_W-1:0]  res1,
  output logic              res_timeout,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_FIRE   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam int N_OPS = 28;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [4:0]        word_cnt;
  logic [TW-1:0]     wait_cnt;
  logic [WORD_W-1:0] ops [N_OPS];
  logic              got0;
  logic              got1;

  logic accept;
  logic last_word;
  logic cap_en;
  logic cap0;
  logic cap1;
  logic complete;
  logic timed_out;
  logic handshake;

  // Handshake and capture qualifiers shared by the state and datapath logic.
  assign s_ready   = (state == ST_LOAD) && !rst;
  assign accept    = s_valid && s_ready;
  assign last_word = accept && (word_cnt == 5'd31);
  assign cap_en    = (state == ST_FIRE) || (state == ST_WAIT);
  assign cap0      = cap_en && out0_ready;
  assign cap1      = cap_en && out1_ready;
  assign complete  = (got0 || cap0) && (got1 || cap1);
  assign timed_out = (state == ST_WAIT) && !complete && (wait_cnt == T_LAST);
  assign handshake = (state == ST_RESULT) && res_valid && res_ready;

  // Next-state selection; FIRE lasts exactly one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:   if (last_word) state_nx = ST_FIRE;
      ST_FIRE:   state_nx = ST_WAIT;
      ST_WAIT:   if (complete || timed_out) state_nx = ST_RESULT;
      ST_RESULT: if (handshake) state_nx = ST_LOAD;
      default:   state_nx = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  // Word counter picks the destination register; it wraps to 0 after word 31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            word_cnt <= '0;
    else if (handshake) word_cnt <= '0;
    else if (accept)    word_cnt <= word_cnt + 5'd1;
  end

  // Wait-cycle counter: zero outside WAIT, so it starts at 0 on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   wait_cnt <= '0;
    else if (state == ST_WAIT) wait_cnt <= wait_cnt + TW'(1);
    else                       wait_cnt <= '0;
  end

  // Operand registers: each one loads only when its own word is accepted and
  // otherwise holds, so the DNN may sample them late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
    end else begin
      for (int i = 0; i < N_OPS; i++) begin
        if (accept && (word_cnt == 5'(i))) ops[i] <= s_data;
      end
    end
  end

  // Start pulse to the DNN, high for exactly the FIRE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= last_word;
  end

  // Result set is valid for the whole time the FSM sits in RESULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_valid <= 1'b0;
    else     res_valid <= (state_nx == ST_RESULT);
  end

  // Result capture; on timeout any result that never arrived is forced to 0
  // so a stale value from an earlier transaction is never reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res0        <= '0;
      res1        <= '0;
      got0        <= 1'b0;
      got1        <= 1'b0;
      res_timeout <= 1'b0;
    end else if (handshake) begin
      got0        <= 1'b0;
      got1        <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (cap0) begin
        res0 <= out0;
        got0 <= 1'b1;
      end
      if (cap1) begin
        res1 <= out1;
        got1 <= 1'b1;
      end
      if (timed_out) begin
        res_timeout <= 1'b1;
        if (!got0 && !cap0) res0 <= '0;
        if (!got1 && !cap1) res1 <= '0;
      end
    end
  end

  // Operand bus in stream order.
  assign x0  = ops[0];
  assign x1  = ops[1];
  assign x2  = ops[2];
  assign x3  = ops[3];
  assign w04 = ops[4];
  assign w14 = ops[5];
  assign w24 = ops[6];
  assign w34 = ops[7];
  assign w05 = ops[8];
  assign w15 = ops[9];
  assign w25 = ops[10];
  assign w35 = ops[11];
  assign w06 = ops[12];
  assign w16 = ops[13];
  assign w26 = ops[14];
  assign w36 = ops[15];
  assign w07 = ops[16];
  assign w17 = ops[17];
  assign w27 = ops[18];
  assign w37 = ops[19];
  assign w48 = ops[20];
  assign w58 = ops[21];
  assign w68 = ops[22];
  assign w78 = ops[23];
  assign w49 = ops[24];
  assign w59 = ops[25];
  assign w69 = ops[26];
  assign w79 = ops[27];

endmodule

// File: tb/tb_dnn_operand_sequencer.sv
// Testbench for dnn_operand_sequencer: table-driven operand loads plus
// hand-written sequences for result strobes, timeout and reset corners.

module tb_dnn_operand_sequencer;

  localparam int WORD_W  = 5;
  localparam int OUT_W   = 17;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] x0, x1, x2, x3;
  logic [WORD_W-1:0] w04, w14, w24, w34, w05, w15, w25, w35;
  logic [WORD_W-1:0] w06, w16, w26, w36, w07, w17, w27, w37;
  logic [WORD_W-1:0] w48, w58, w68, w78, w49, w59, w69, w79;
  logic              in_ready;
  logic [OUT_W-1:0]  out0, out1;
  logic              out0_ready, out1_ready;
  logic [OUT_W-1:0]  res0, res1;
  logic              res_timeout;
  logic              res_valid;
  logic              res_ready;

  typedef struct {
    logic [4:0] word;
    logic [4:0] exp;
  } op_vec_t;

  op_vec_t golden [32];
  op_vec_t alt    [32];

  logic [4:0] gw [32] = '{
    5'b00100, 5'b00011, 5'b11110, 5'b01001,
    5'b01100, 5'b10011, 5'b00111, 5'b11010,
    5'b00001, 5'b11111, 5'b01010, 5'b10101,
    5'b00110, 5'b11000, 5'b01111, 5'b10000,
    5'b00010, 5'b11101, 5'b01011, 5'b10110,
    5'b00101, 5'b11011, 5'b01110, 5'b10001,
    5'b01000, 5'b11100, 5'b00000, 5'b00110,
    5'b11111, 5'b10101, 5'b01010, 5'b11001
  };

  int n_cmp    = 0;
  int n_err    = 0;
  int fire_cnt = 0;

  dnn_operand_sequencer #(
    .WORD_W(WORD_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w14(w14), .w24(w24), .w34(w34),
    .w05(w05), .w15(w15), .w25(w25), .w35(w35),
    .w06(w06), .w16(w16), .w26(w26), .w36(w36),
    .w07(w07), .w17(w17), .w27(w27), .w37(w37),
    .w48(w48), .w58(w58), .w68(w68), .w78(w78),
    .w49(w49), .w59(w59), .w69(w69), .w79(w79),
    .in_ready(in_ready),
    .out0(out0), .out1(out1),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .res0(res0), .res1(res1),
    .res_timeout(res_timeout), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts cycles in which the start pulse is seen.
  always @(negedge clk) begin
    if (in_ready) fire_cnt <= fire_cnt + 1;
  end

  // Hard stop in case the run wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_op(input int i);
    case (i)
      0: return x0;   1: return x1;   2: return x2;   3: return x3;
      4: return w04;  5: return w14;  6: return w24;  7: return w34;
      8: return w05;  9: return w15;  10: return w25; 11: return w35;
      12: return w06; 13: return w16; 14: return w26; 15: return w36;
      16: return w07; 17: return w17; 18: return w27; 19: return w37;
      20: return w48; 21: return w58; 22: return w68; 23: return w78;
      24: return w49; 25: return w59; 26: return w69; 27: return w79;
      default: return 5'd0;
    endcase
  endfunction

  // Streams one 32-word table, optionally with random s_valid gaps; returns
  // at the negedge after the 32nd word was accepted (the FIRE cycle).
  task automatic applyStimulus(input bit use_alt, input int max_gap);
    for (int i = 0; i < 32; i++) begin
      if (max_gap > 0) begin
        int g;
        g = int'($urandom_range(max_gap, 0));
        repeat (g) begin
          s_valid = 1'b0;
          s_data  = 5'($urandom);
          @(negedge clk);
          checkOutput("s_ready_gap", 32'(s_ready), 32'd1);
        end
      end
      s_valid = 1'b1;
      s_data  = use_alt ? alt[i].word : golden[i].word;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic check_ops(input bit use_alt);
    for (int i = 0; i < 28; i++) begin
      checkOutput($sformatf("op%0d", i), 32'(dut_op(i)),
                  32'(use_alt ? alt[i].exp : golden[i].exp));
    end
  endtask

  task automatic wait_result(input int bound);
    int w;
    w = 0;
    while (!res_valid && w < bound) begin
      @(negedge clk);
      w++;
    end
    checkOutput("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic do_handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("hs_res_valid", 32'(res_valid), 32'd0);
    checkOutput("hs_s_ready", 32'(s_ready), 32'd1);
    checkOutput("hs_res_timeout", 32'(res_timeout), 32'd0);
  endtask

  initial begin
    int f0;
    int w;

    for (int i = 0; i < 32; i++) begin
      golden[i] = '{gw[i], gw[i]};
      alt[i]    = '{5'(i * 7 + 3), 5'(i * 7 + 3)};
    end

    rst        = 1'b1;
    s_data     = '0;
    s_valid    = 1'b0;
    out0       = '0;
    out1       = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    res_ready  = 1'b0;

    // Reset values.
    #2;
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res0", 32'(res0), 32'd0);
    checkOutput("rst_x0", 32'(x0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd0);

    // Golden load with a 2-cycle responder.
    $display("[TB] golden load");
    f0 = fire_cnt;
    applyStimulus(1'b0, 0);
    checkOutput("gold_fire", 32'(in_ready), 32'd1);
    checkOutput("gold_fire_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    checkOutput("gold_fire_end", 32'(in_ready), 32'd0);
    out0 = 17'h1FD2A; out1 = 17'h1FEA4; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0; out1_ready = 1'b0; out0 = 17'h0BEEF; out1 = 17'h01234;
    checkOutput("gold_res_valid", 32'(res_valid), 32'd1);
    checkOutput("gold_res0", 32'(res0), 32'h1FD2A);
    checkOutput("gold_res1", 32'(res1), 32'h1FEA4);
    checkOutput("gold_timeout", 32'(res_timeout), 32'd0);
    checkOutput("gold_x0", 32'(x0), 32'b00100);
    checkOutput("gold_w34", 32'(w34), 32'b11010);
    checkOutput("gold_w79", 32'(w79), 32'b00110);
    checkOutput("gold_fire_count", 32'(fire_cnt - f0), 32'd1);
    check_ops(1'b0);
    do_handshake();

    // Backpressure on both sides; strobes in RESULT must be ignored.
    $display("[TB] backpressure");
    applyStimulus(1'b0, 2);
    checkOutput("bp_fire", 32'(in_ready), 32'd1);
    @(negedge clk);
    out0 = 17'h1FD2A; out1 = 17'h1FEA4; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0; out1_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
      checkOutput("bp_res0", 32'(res0), 32'h1FD2A);
      checkOutput("bp_res1", 32'(res1), 32'h1FEA4);
      out0 = 17'(c + 17'h00100); out1 = 17'(c + 17'h00200);
      out0_ready = 1'b1; out1_ready = 1'b1;
      @(negedge clk);
    end
    out0_ready = 1'b0; out1_ready = 1'b0;
    checkOutput("bp_res0_held", 32'(res0), 32'h1FD2A);
    check_ops(1'b0);
    do_handshake();

    // Strobe in LOAD ignored; out1 arrives 3 cycles before out0.
    $display("[TB] strobe ordering");
    out0 = 17'h00555; out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    applyStimulus(1'b1, 0);
    checkOutput("ord_fire", 32'(in_ready), 32'd1);
    @(negedge clk);
    out1 = 17'h0ABCD; out1_ready = 1'b1;
    @(negedge clk);
    out1_ready = 1'b0; out1 = 17'h00777;
    for (int c = 0; c < 3; c++) begin
      checkOutput("ord_res_valid_early", 32'(res_valid), 32'd0);
      if (c < 2) @(negedge clk);
    end
    out0 = 17'h1F00F; out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    checkOutput("ord_res_valid", 32'(res_valid), 32'd1);
    checkOutput("ord_res0", 32'(res0), 32'h1F00F);
    checkOutput("ord_res1", 32'(res1), 32'h0ABCD);
    checkOutput("ord_timeout", 32'(res_timeout), 32'd0);
    check_ops(1'b1);
    do_handshake();

    // Both strobes during FIRE: minimum latency of 2 cycles after last word.
    $display("[TB] same-cycle strobes in FIRE");
    applyStimulus(1'b0, 0);
    out0 = 17'h00011; out1 = 17'h1FFFF; out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0; out1_ready = 1'b0;
    checkOutput("min_res_valid_wait", 32'(res_valid), 32'd0);
    @(negedge clk);
    checkOutput("min_res_valid", 32'(res_valid), 32'd1);
    checkOutput("min_res0", 32'(res0), 32'h00011);
    checkOutput("min_res1", 32'(res1), 32'h1FFFF);
    do_handshake();

    // Silent responder: RESULT after exactly TIMEOUT WAIT cycles.
    $display("[TB] silent timeout");
    applyStimulus(1'b0, 0);
    checkOutput("to_fire", 32'(in_ready), 32'd1);
    w = 0;
    @(negedge clk);
    while (!res_valid && w < 40) begin
      w++;
      @(negedge clk);
    end
    checkOutput("to_wait_cycles", 32'(w), 32'(TIMEOUT));
    checkOutput("to_res_valid", 32'(res_valid), 32'd1);
    checkOutput("to_flag", 32'(res_timeout), 32'd1);
    checkOutput("to_res0", 32'(res0), 32'd0);
    checkOutput("to_res1", 32'(res1), 32'd0);
    do_handshake();

    // Only out0 arrives.
    $display("[TB] partial timeout");
    applyStimulus(1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    out0 = 17'd1173; out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    checkOutput("pt_res_valid_early", 32'(res_valid), 32'd0);
    wait_result(40);
    checkOutput("pt_res0", 32'(res0), 32'd1173);
    checkOutput("pt_res1", 32'(res1), 32'd0);
    checkOutput("pt_flag", 32'(res_timeout), 32'd1);
    do_handshake();

    // Reset after 10 words, then a fresh stream.
    $display("[TB] reset mid-load");
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = golden[i].word;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checkOutput("ml_partial_x0", 32'(x0), 32'(golden[0].exp));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ml_rst_x0", 32'(x0), 32'd0);
    checkOutput("ml_rst_w14", 32'(w14), 32'd0);
    checkOutput("ml_rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    f0 = fire_cnt;
    applyStimulus(1'b1, 0);
    checkOutput("ml_fire", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("ml_fire_end", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("ml_fire_count", 32'(fire_cnt - f0), 32'd1);
    check_ops(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
